ysyx_2022040010_ex_mem_buf: RTL and testbench

- Execute-to-memory pipeline buffer. It sits directly downstream of the execute datapath (shifter, adder, logic unit) and registers the selected execute result for the memory stage.
- Two-entry skid buffer with valid/ready handshakes on both sides, so ex_ready has no combinational path from mem_ready.
- Also exports a forwarding tap from the head entry for the decode-stage hazard bypass.

---
 rtl/ysyx_2022040010_ex_mem_buf.sv | 161 ++++++++++++++++
 tb/tb_ysyx_2022040010_ex_mem_buf.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_ex_mem_buf.sv
// ----------------------------------------------------------------------------
// ysyx_2022040010_ex_mem_buf
//
// Execute-to-memory pipeline buffer. This is a two-entry skid buffer that
// registers the selected execute result for the memory stage. ex_ready is
// taken from registered state only, so it never depends on mem_ready in the
// same cycle. The head entry also drives a forwarding tap for the
// decode-stage bypass.
//
// Ports:
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   flush             synchronous flush; empties both entries and drops any
//                     push made in the same cycle
//   ex_valid/ex_ready upstream handshake
//   ex_result, ex_rd, ex_rd_wen, ex_pc, ex_mem_op
//                     upstream payload
//   mem_valid/mem_ready
//                     downstream handshake; the payload comes straight from
//                     the head entry
//   mem_result, mem_rd, mem_rd_wen, mem_pc, mem_mem_op
//                     head payload
//   fwd_valid, fwd_rd, fwd_data
//                     bypass tap from the head entry. Loads and x0 writes
//                     are never forwardable.
//   stall_cnt         (only with `YSYX_EXMEM_STALL_CNT_EN) counts the cycles
//                     in which ex_valid=1 and ex_ready=0. It wraps and is
//                     not cleared by flush.
//
// Optional feature macro: YSYX_EXMEM_STALL_CNT_EN
// ----------------------------------------------------------------------------
module ysyx_2022040010_ex_mem_buf #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [RW-1:0]   ex_rd,
  input  logic            ex_rd_wen,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [3:0]      ex_mem_op,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_result,
  output logic [RW-1:0]   mem_rd,
  output logic            mem_rd_wen,
  output logic [XLEN-1:0] mem_pc,
  output logic [3:0]      mem_mem_op,
  output logic            fwd_valid,
  output logic [RW-1:0]   fwd_rd,
  output logic [XLEN-1:0] fwd_data
`ifdef YSYX_EXMEM_STALL_CNT_EN
  ,
  output logic [63:0]     stall_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd;
    logic            rd_wen;
    logic [XLEN-1:0] pc;
    logic [3:0]      mem_op;
  } entry_t;

  entry_t r_h;       // head entry, visible on mem_*
  entry_t r_s;       // skid entry, filled only when the head is stalled
  entry_t w_in;
  entry_t w_h_nxt;
  entry_t w_s_nxt;
  logic   w_push;
  logic   w_pop;

  assign ex_ready = ~r_s.valid;
  assign w_push   = ex_valid & ex_ready;
  assign w_pop    = r_h.valid & mem_ready;

  // NOTE: every field written in this block gets a default first (the
  // current register value), so no path leaves a signal unassigned and no
  // latch is inferred.
  always_comb begin
    w_in.valid  = 1'b1;
    w_in.result = ex_result;
    w_in.rd     = ex_rd;
    w_in.rd_wen = ex_rd_wen;
    w_in.pc     = ex_pc;
    w_in.mem_op = ex_mem_op;

    w_h_nxt = r_h;
    w_s_nxt = r_s;

    if (flush) begin
      // The payload may keep stale values. They cannot be observed while
      // valid is 0.
      w_h_nxt.valid = 1'b0;
      w_s_nxt.valid = 1'b0;
    end else if (!r_h.valid || w_pop) begin
      // The head is free this cycle. Refill it from the skid entry first to
      // keep FIFO order, and only then from a new push.
      if (r_s.valid) begin
        w_h_nxt       = r_s;
        w_s_nxt.valid = 1'b0;
      end else if (w_push) begin
        w_h_nxt = w_in;
      end else begin
        w_h_nxt.valid = 1'b0;
      end
    end else if (w_push) begin
      // The head is stalled. A push can only happen here when the skid
      // entry is empty, so the push lands in the skid entry.
      w_s_nxt = w_in;
    end
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples its pre-edge value. The payload registers are reset
  // too, because the data outputs must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_s <= '0;
    end else begin
      r_h <= w_h_nxt;
      r_s <= w_s_nxt;
    end
  end

  assign mem_valid  = r_h.valid;
  assign mem_result = r_h.result;
  assign mem_rd     = r_h.rd;
  assign mem_rd_wen = r_h.rd_wen;
  assign mem_pc     = r_h.pc;
  assign mem_mem_op = r_h.mem_op;

  // A load's result only exists after the memory access, so it cannot be
  // bypassed from this stage.
  assign fwd_valid = r_h.valid & r_h.rd_wen & (r_h.rd != '0) & (r_h.mem_op == 4'd0);
  assign fwd_rd    = r_h.rd;
  assign fwd_data  = r_h.result;

`ifdef YSYX_EXMEM_STALL_CNT_EN
  logic [63:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 64'd0;
    end else if (ex_valid && !ex_ready) begin
      r_stall_cnt <= r_stall_cnt + 64'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Without the counter, the buffer behaves the same and has no extra state.
`endif

endmodule

// File: tb/tb_ysyx_2022040010_ex_mem_buf.sv
// ----------------------------------------------------------------------------
// tb_ysyx_2022040010_ex_mem_buf
//
// Directed testbench for the execute-to-memory skid buffer. Inputs change
// 1 ns after a rising edge. Outputs are checked at the same point, so each
// check sees the state that the previous edge produced.
// ----------------------------------------------------------------------------
module tb_ysyx_2022040010_ex_mem_buf;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_result;
  logic [RW-1:0]   ex_rd;
  logic            ex_rd_wen;
  logic [XLEN-1:0] ex_pc;
  logic [3:0]      ex_mem_op;
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_result;
  logic [RW-1:0]   mem_rd;
  logic            mem_rd_wen;
  logic [XLEN-1:0] mem_pc;
  logic [3:0]      mem_mem_op;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;
`ifdef YSYX_EXMEM_STALL_CNT_EN
  logic [63:0]     stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ysyx_2022040010_ex_mem_buf #(.XLEN(XLEN), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_result  (ex_result),
    .ex_rd      (ex_rd),
    .ex_rd_wen  (ex_rd_wen),
    .ex_pc      (ex_pc),
    .ex_mem_op  (ex_mem_op),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_rd_wen (mem_rd_wen),
    .mem_pc     (mem_pc),
    .mem_mem_op (mem_mem_op),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`ifdef YSYX_EXMEM_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] rd,
                       input logic wen, input logic [63:0] pc, input logic [3:0] op);
    ex_valid  = v;
    ex_result = res;
    ex_rd     = rd;
    ex_rd_wen = wen;
    ex_pc     = pc;
    ex_mem_op = op;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);

    // Reset state
    #12;
    check("rst mem_valid", 64'(mem_valid), 64'd0);
    check("rst ex_ready", 64'(ex_ready), 64'd1);
    check("rst fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst mem_result", mem_result, 64'd0);
    check("rst mem_pc", mem_pc, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single push, with the memory stage ready
    mem_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_FFFF_FFFF, 5'd5, 1'b1, 64'h1000, 4'd0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);
    check("t1 mem_valid", 64'(mem_valid), 64'd1);
    check("t1 mem_result", mem_result, 64'h0000_0000_FFFF_FFFF);
    check("t1 mem_pc", mem_pc, 64'h1000);
    check("t1 fwd_valid", 64'(fwd_valid), 64'd1);
    check("t1 fwd_rd", 64'(fwd_rd), 64'd5);
    check("t1 fwd_data", fwd_data, 64'h0000_0000_FFFF_FFFF);
    tick();
    check("t1 drained", 64'(mem_valid), 64'd0);

    // Fill to FULL with A, B. Then hold C on ex_valid.
    mem_ready = 1'b0;
    drive(1'b1, 64'hA, 5'd1, 1'b1, 64'h100, 4'd0);
    tick();
    check("t2 ready after A", 64'(ex_ready), 64'd1);
    drive(1'b1, 64'hB, 5'd2, 1'b1, 64'h104, 4'd0);
    tick();
    check("t2 full ex_ready", 64'(ex_ready), 64'd0);
    check("t2 head is A", mem_result, 64'hA);
    drive(1'b1, 64'hC, 5'd3, 1'b1, 64'h108, 4'd0);
    tick();
    check("t2 hold A result", mem_result, 64'hA);
    check("t2 hold A pc", mem_pc, 64'h100);
    check("t2 hold A rd", 64'(mem_rd), 64'd1);
    tick();
    check("t2 hold A valid", 64'(mem_valid), 64'd1);
    mem_ready = 1'b1;
    tick();  // A pops. C is still refused.
    check("t3 head is B", mem_result, 64'hB);
    check("t3 ready back", 64'(ex_ready), 64'd1);
    tick();  // B pops, C is pushed
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);
    check("t3 head is C", mem_result, 64'hC);
    check("t3 C pc", mem_pc, 64'h108);
    tick();
    check("t3 empty", 64'(mem_valid), 64'd0);
`ifdef YSYX_EXMEM_STALL_CNT_EN
    check("t3 stall_cnt", stall_cnt, 64'd3);
`endif

    // Flush while FULL, with D presented in the same cycle
    mem_ready = 1'b0;
    drive(1'b1, 64'hE, 5'd4, 1'b1, 64'h200, 4'd0);
    tick();
    drive(1'b1, 64'hF, 5'd6, 1'b1, 64'h204, 4'd0);
    tick();
    check("t4 full", 64'(ex_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 64'hD, 5'd8, 1'b1, 64'h208, 4'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);
    mem_ready = 1'b1;
    check("t4 flush mem_valid", 64'(mem_valid), 64'd0);
    check("t4 flush ex_ready", 64'(ex_ready), 64'd1);
    check("t4 flush fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    check("t4 D never seen", 64'(mem_valid), 64'd0);

    // Forwarding qualifiers
    mem_ready = 1'b0;
    drive(1'b1, 64'h77, 5'd7, 1'b1, 64'h300, 4'd3);
    tick();
    check("t5 load valid", 64'(mem_valid), 64'd1);
    check("t5 load op", 64'(mem_mem_op), 64'd3);
    check("t5 load fwd", 64'(fwd_valid), 64'd0);
    mem_ready = 1'b1;
    drive(1'b1, 64'h55, 5'd0, 1'b1, 64'h304, 4'd0);
    tick();
    check("t5 x0 rd", 64'(mem_rd), 64'd0);
    check("t5 x0 wen", 64'(mem_rd_wen), 64'd1);
    check("t5 x0 result", mem_result, 64'h55);
    check("t5 x0 fwd", 64'(fwd_valid), 64'd0);
    drive(1'b1, 64'h66, 5'd9, 1'b0, 64'h308, 4'd0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);
    check("t5 nowen fwd", 64'(fwd_valid), 64'd0);
    check("t5 nowen rd", 64'(fwd_rd), 64'd9);
    tick();

    // Asynchronous reset while FULL
    mem_ready = 1'b0;
    drive(1'b1, 64'h1, 5'd1, 1'b1, 64'h400, 4'd0);
    tick();
    drive(1'b1, 64'h2, 5'd2, 1'b1, 64'h404, 4'd0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 4'd0);
    check("t6 full", 64'(ex_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 async mem_valid", 64'(mem_valid), 64'd0);
    check("t6 async result", mem_result, 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("t6 ex_ready", 64'(ex_ready), 64'd1);
    check("t6 still empty", 64'(mem_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
